// File: rtl/rv32i_fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package rv32i_fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// Instruction buffer between the memory response port and decode.
// Flush wins over push/pop.
module rv32i_fetch_fifo
  import rv32i_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rv32i_fetch_block.sv
// RV32I fetch stage: PC, imem request/response tracking, redirect drop logic.
// Optional misaligned-redirect trap: define RV32I_FETCH_MISALIGN_TRAP_EN.
module rv32i_fetch_block
  import rv32i_fetch_pkg::*;
#(
  parameter int          INSTRUCTION_WIDTH = 32,
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter int          FIFO_DEPTH        = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [INSTRUCTION_WIDTH-1:0] imem_req_addr,
  input  logic                         imem_rsp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rsp_data,
  input  logic                         redirect_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] redirect_pc,
  input  logic                         stall,
  output logic [INSTRUCTION_WIDTH-1:0] inst_o,
  output logic [INSTRUCTION_WIDTH-1:0] inst_pc_o,
  output logic                         inst_valid_o,
  output logic                         fetch_misaligned_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [31:0]   r_pc_hold;
  logic [31:0]   r_mis_pc;
  logic          r_misaligned;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;

  logic [31:0]   w_redirect_pc;
  logic          w_redirect_misaligned;
  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic [CW:0]   w_inflight;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_drop_rsp;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_inst_pc;

  assign w_redirect_misaligned = TRAP_EN && (redirect_pc[1:0] != 2'b00);
  assign w_redirect_pc         = TRAP_EN ? redirect_pc : {redirect_pc[31:2], 2'b00};

  // Credits: buffered words plus words still in flight never exceed FIFO_DEPTH.
  assign w_inflight  = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
  assign w_req_valid = rst_n && !redirect_valid && !r_misaligned && !w_fifo_full
                       && (w_inflight < (CW+1)'(FIFO_DEPTH));
  assign w_req_fire  = w_req_valid && imem_req_ready;

  assign w_drop_rsp   = imem_rsp_valid && ((r_drop != '0) || redirect_valid);
  assign w_push       = imem_rsp_valid && !w_drop_rsp;
  assign w_pop        = !w_fifo_empty && !stall;
  assign w_push_entry = '{inst: imem_rsp_data, pc: r_rsp_pc};

  rv32i_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count),
    .head      (w_head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_pc_hold     <= '0;
      r_mis_pc      <= '0;
      r_misaligned  <= 1'b0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_pc_hold     <= w_inst_pc;
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_pc         <= w_redirect_pc;
        r_rsp_pc     <= w_redirect_pc;
        r_drop       <= r_outstanding - CW'(imem_rsp_valid);
        r_misaligned <= w_redirect_misaligned;
        if (w_redirect_misaligned) r_mis_pc <= w_redirect_pc;
      end else begin
        if (w_req_fire) r_pc     <= r_pc + PC_STEP;
        if (w_push)     r_rsp_pc <= r_rsp_pc + PC_STEP;
        if (w_drop_rsp) r_drop   <= r_drop - 1'b1;
      end
    end
  end

  assign w_inst_pc = r_misaligned ? r_mis_pc : (w_fifo_empty ? r_pc_hold : w_head.pc);

  assign imem_req_valid     = w_req_valid;
  assign imem_req_addr      = r_pc;
  assign inst_valid_o       = !w_fifo_empty;
  assign inst_o             = w_fifo_empty ? NOP_INST : w_head.inst;
  assign inst_pc_o          = w_inst_pc;
  assign fetch_misaligned_o = r_misaligned;

  a_no_stray_rsp : assert property (@(posedge clk) disable iff (!rst_n)
                                    imem_rsp_valid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_rv32i_fetch_block.sv
// Self-checking bench for rv32i_fetch_block with an in-order imem model and scoreboard.
`timescale 1ns/1ps
module tb_rv32i_fetch_block;
  import rv32i_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        fetch_misaligned_o;

  always #5 clk = ~clk;

  rv32i_fetch_block dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .imem_req_valid     (imem_req_valid),
    .imem_req_ready     (imem_req_ready),
    .imem_req_addr      (imem_req_addr),
    .imem_rsp_valid     (imem_rsp_valid),
    .imem_rsp_data      (imem_rsp_data),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .stall              (stall),
    .inst_o             (inst_o),
    .inst_pc_o          (inst_pc_o),
    .inst_valid_o       (inst_valid_o),
    .fetch_misaligned_o (fetch_misaligned_o)
  );

  typedef struct { logic [31:0] addr; int due; } mem_req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_pc;
    logic        exp_mis;
    int          lat;
    int          pre_out;
  } vec_t;

  mem_req_t    mem_q[$];
  exp_t        sb_q[$];
  vec_t        vecs[4];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          ready_pct = 100;
  int          stall_pct = 0;
  int          pops = 0;
  int          reqs = 0;
  logic [31:0] model_fetch_pc = '0;
  logic        tb_mis = 1'b0;
  logic [31:0] tb_mis_pc = '0;
  logic        last_valid, last_req, last_mis;
  logic [31:0] last_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  function automatic logic target_mis(input logic [31:0] t);
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample/check at negedge, then drive the next inputs just after posedge.
  task automatic step();
    int   due;
    exp_t e;
    mem_req_t m;
    @(negedge clk);
    last_valid = inst_valid_o;
    last_req   = imem_req_valid;
    last_mis   = fetch_misaligned_o;
    last_pc    = inst_pc_o;
    check("misaligned_flag", fetch_misaligned_o, tb_mis);
    if (tb_mis) begin
      check("mis_no_request", imem_req_valid, 1'b0);
      check("mis_inst_pc", inst_pc_o, tb_mis_pc);
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, model_fetch_pc);
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{imem_req_addr, due});
      sb_q.push_back('{imem_req_addr, mem_word(imem_req_addr)});
      model_fetch_pc = model_fetch_pc + 32'd4;
      reqs++;
    end
    if (inst_valid_o && !stall) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_inst: got pc %h, nothing expected (cycle %0d)", inst_pc_o, cyc);
      end else begin
        e = sb_q.pop_front();
        check("inst_pc", inst_pc_o, e.pc);
        check("inst_data", inst_o, e.inst);
      end
      pops++;
    end
    if (!inst_valid_o) check("nop_when_empty", inst_o, NOP_INST);
    if (redirect_valid) begin
      check("no_req_on_redirect", imem_req_valid, 1'b0);
      sb_q.delete();
      model_fetch_pc = eff_target(redirect_pc);
      tb_mis    = target_mis(redirect_pc);
      tb_mis_pc = redirect_pc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(m.addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    imem_req_ready = ($urandom_range(99, 0) < ready_pct);
    if (stall_pct > 0) stall = ($urandom_range(99, 0) < stall_pct);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] hold_pc;
    logic        got;
    logic [31:0] first_pc;
    int          reqs0, pops0;

    vecs[0] = '{32'h0000_0100, 32'h0000_0100, 1'b0, 4, 2};
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    vecs[1] = '{32'h0000_0102, 32'h0000_0102, 1'b1, 2, 0};
`else
    vecs[1] = '{32'h0000_0102, 32'h0000_0100, 1'b0, 2, 0};
`endif
    vecs[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1, 0};
    vecs[3] = '{32'h0000_0040, 32'h0000_0040, 1'b0, 3, 1};

    // Reset
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_inst_valid", inst_valid_o, 1'b0);
    check("rst_inst", inst_o, NOP_INST);
    check("rst_inst_pc", inst_pc_o, 32'h0);
    check("rst_misaligned", fetch_misaligned_o, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_fetch_pc = 32'h0;

    // First fetch latency with zero-wait memory
    step();
    check("c0_req_valid", last_req, 1'b1);
    check("c0_inst_valid", last_valid, 1'b0);
    step();
    check("c1_inst_valid", last_valid, 1'b0);
    step();
    check("c2_inst_valid", last_valid, 1'b1);
    check("c2_inst_pc", last_pc, 32'h0);
    repeat (8) step();
    check("initial_pops_ge4", (pops >= 4) ? 32'd1 : 32'd0, 32'd1);

    // Stall holds the head and stops requests once the buffer is full
    stall = 1'b1;
    repeat (3) step();
    hold_pc = last_pc;
    repeat (2) step();
    check("stall_req_off", last_req, 1'b0);
    check("stall_valid", last_valid, 1'b1);
    check("stall_head_held", last_pc, hold_pc);
    pops0 = pops;
    stall = 1'b0;
    repeat (8) step();
    check("stall_release_progress", (pops > pops0) ? 32'd1 : 32'd0, 32'd1);

    // Redirect table
    for (int i = 0; i < 4; i++) begin
      lat_min = vecs[i].lat;
      lat_max = vecs[i].lat;
      for (int k = 0; k < 20 && mem_q.size() < vecs[i].pre_out; k++) step();
      if (vecs[i].pre_out > 0)
        check("pre_outstanding", (mem_q.size() >= vecs[i].pre_out) ? 32'd1 : 32'd0, 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = vecs[i].target;
      step();
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
      reqs0 = reqs;
      step();
      check("flush_valid", last_valid, 1'b0);
      if (vecs[i].exp_mis) begin
        repeat (8) step();
        check("tbl_mis_flag", last_mis, 1'b1);
        check("tbl_mis_pc", last_pc, vecs[i].exp_pc);
        check("tbl_mis_no_reqs", reqs, reqs0);
      end else begin
        got = 1'b0;
        first_pc = '0;
        for (int k = 0; k < 40 && !got; k++) begin
          step();
          if (last_valid) begin
            got = 1'b1;
            first_pc = last_pc;
          end
        end
        check("tbl_seen_valid", got, 1'b1);
        check("tbl_first_pc", first_pc, vecs[i].exp_pc);
        check("tbl_mis_clear", last_mis, 1'b0);
        repeat (6) step();
      end
    end

    // Random ready, latency and stall
    ready_pct = 50;
    lat_min   = 1;
    lat_max   = 4;
    stall_pct = 30;
    pops0 = pops;
    repeat (300) step();
    check("random_progress", (pops - pops0 > 20) ? 32'd1 : 32'd0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv32i_fetch_block.md
Name: rv32i_fetch_block

Overview:
- Instruction-fetch stage directly upstream of the RV32I decode stage.
- Owns the PC and issues word fetches to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words in a small FIFO and presents one instruction per cycle to decode.
- Handles redirects from execute (branch/jump) by flushing the buffer and discarding in-flight responses.

Parameters:
- INSTRUCTION_WIDTH, 32, width of instruction word and PC.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; responses are in request order.
- imem_rsp_data  in  32  fetched instruction.
- redirect_valid  in  1  execute requests PC change.
- redirect_pc  in  32  new PC.
- stall  in  1  decode cannot accept this cycle.
- inst_o  out  32  instruction to decode.
- inst_pc_o  out  32  PC of inst_o.
- inst_valid_o  out  1  inst_o is a real instruction.
- fetch_misaligned_o  out  1  misaligned redirect flag (see Optional Feature).

Behaviour:
- Reset (sampled on posedge clk with rst_n=0): pc=RESET_PC, FIFO empty, outstanding=0, drop=0.
- Outputs during and after reset: imem_req_valid=0, inst_valid_o=0, inst_o=32'h0000_0013 (NOP), inst_pc_o=0, fetch_misaligned_o=0.
- Request rule: imem_req_valid=1 when fifo_count + outstanding < FIFO_DEPTH and redirect_valid=0.
  - imem_req_addr = pc.
  - On handshake (valid & ready): pc += 4 (wraps modulo 2^32); outstanding++.
- Response rule: every imem_rsp_valid decrements outstanding.
  - If drop>0: discard the word and decrement drop.
  - Else: push {data, pc_of_request} into the FIFO. Track request PCs in a parallel PC queue, or derive them from a response-PC counter.
  - The request rule guarantees the FIFO never overflows. An imem_rsp_valid with outstanding=0 is illegal; flag it by assertion only.
- Output and pop:
  - FIFO non-empty: inst_valid_o=1, inst_o/inst_pc_o = head entry.
  - FIFO empty: inst_valid_o=0, inst_o=NOP, inst_pc_o holds its last value.
  - Pop when inst_valid_o & ~stall.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Full FIFO plus stall: requests stop and the head is held.
- Latency: the first request issues the cycle after reset deasserts. With zero-wait memory (response the cycle after accept), inst_valid_o rises 2 cycles after reset release, then sustains 1 instruction per cycle.
- Redirect (highest priority), in the same cycle:
  - FIFO flushed (next cycle inst_valid_o=0).
  - pc <= redirect_pc.
  - drop <= outstanding minus any response arriving this cycle. A response arriving in the redirect cycle is itself discarded.
  - No request issued in the redirect cycle.
  - Fetching resumes the next cycle from redirect_pc, even while drop>0.
- Back-to-back redirects: the last one wins and drop accumulates correctly.
- Reset mid-operation: all state is cleared. Memory must also be reset on the same rst_n; later stray responses are not guarded.

Optional Feature:
- Macro RV32I_FETCH_MISALIGN_TRAP_EN.
- Defined, when redirect_pc[1:0] != 0:
  - Fetch halts: imem_req_valid=0 and the FIFO is flushed.
  - fetch_misaligned_o=1 and inst_pc_o=redirect_pc.
  - Both persist until the next aligned redirect or reset.
- Undefined: redirect_pc[1:0] is forced to 2'b00; fetch_misaligned_o is tied to 0.

Decomposition:
- Package rv32i_fetch_pkg holds:
  - NOP_INST = 32'h0000_0013
  - PC_STEP = 4
  - fetch_entry_t struct {inst[31:0], pc[31:0]}
- One sub-module: rv32i_fetch_fifo.
  - Synchronous FIFO of fetch_entry_t, parameterised by FIFO_DEPTH.
  - Ports: push, pop, flush, full, empty, count, head.

Test Plan:
- Reset release, imem always ready, 1-cycle response: inst_valid_o high at cycle 2; PCs 0,4,8,C in order; inst_o matches memory image.
- stall=1 for 5 cycles: FIFO fills to 2, imem_req_valid drops, head PC held; release resumes with no loss or duplication.
- Redirect to 0x100 with 2 responses outstanding: both discarded; next inst_valid_o shows PC 0x100.
- imem_req_ready random 50%, response latency random 1–4 cycles: output PC stream is strictly +4 with no gaps or duplicates.
- pc=0xFFFF_FFFC: next fetch address wraps to 0x0000_0000.
- Redirect to 0x102:
  - With macro: fetch_misaligned_o=1 and no requests.
  - Without macro: fetch proceeds from 0x100.
